// File: rtl/pc_tx_arb_pkg.sv
// Shared types and constants for the PC_TX word arbiter.
// The HDR state exists only when PC_TX_ARB_HDR_EN is defined.
package pc_tx_arb_pkg;

    localparam int          CNT_W     = 8;
    localparam logic [15:0] HDR_MAGIC = 16'hA5A5;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_XFER = 2'd1
`ifdef PC_TX_ARB_HDR_EN
        ,
        ST_HDR  = 2'd2
`endif
    } arb_state_t;

endpackage

// File: rtl/rr_priority_picker.sv
// Round-robin search: first set request strictly after 'last', wrapping modulo NUM_REQ.
// Purely combinational; 'any' flags that at least one request is set.
module rr_priority_picker #(
    parameter  int NUM_REQ = 4,
    localparam int IW      = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IW-1:0]      last,
    output logic [IW-1:0]      grant,
    output logic               any
);

    logic [IW-1:0] idx;

    // NOTE: every output of a combinational block gets a default first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        grant = '0;
        any   = 1'b0;
        idx   = '0;
        // Offsets 1..NUM_REQ visit every requester once, ending on 'last' itself.
        for (int i = 1; i <= NUM_REQ; i++) begin
            idx = IW'((int'(last) + i) % NUM_REQ);
            if (!any && req[idx]) begin
                any   = 1'b1;
                grant = idx;
            end
        end
    end

endmodule

// File: rtl/pc_tx_arbiter.sv
// Round-robin burst arbiter feeding NUM_REQ word requesters into the PC_TX FIFO.
// Define PC_TX_ARB_HDR_EN to prefix each burst with a {A5A5, 00, grant} header word.
module pc_tx_arbiter
    import pc_tx_arb_pkg::*;
#(
    parameter  int NUM_REQ   = 4,
    parameter  int MAX_BURST = 8,
    localparam int IW        = $clog2(NUM_REQ)
) (
    input  logic                  i_clock,
    input  logic                  i_reset_n,
    input  logic [NUM_REQ-1:0]    i_req_valid,
    input  logic [32*NUM_REQ-1:0] i_req_data,
    output logic [NUM_REQ-1:0]    o_req_ready,
    input  logic                  i_fifo_full,
    output logic                  o_fifo_write_word_cmd,
    output logic [31:0]           o_fifo_write_word_data,
    output logic [IW-1:0]         o_grant_id,
    output logic                  o_busy
);

    localparam logic [CNT_W-1:0] BURST_LAST = CNT_W'(MAX_BURST);

    arb_state_t       state_q, state_d;
    logic [IW-1:0]    grant_q, grant_d;
    logic [IW-1:0]    last_q, last_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic [IW-1:0]    pick_idx;
    logic             pick_any;
    logic             valid_sel;
    logic [31:0]      word_sel;
    logic [NUM_REQ-1:0] ready;
    logic             cmd;
    logic [31:0]      data;

    rr_priority_picker #(
        .NUM_REQ(NUM_REQ)
    ) u_picker (
        .req   (i_req_valid),
        .last  (last_q),
        .grant (pick_idx),
        .any   (pick_any)
    );

    assign valid_sel = i_req_valid[grant_q];
    assign word_sel  = i_req_data[32*grant_q +: 32];

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        last_d  = last_q;
        cnt_d   = cnt_q;
        ready   = '0;
        cmd     = 1'b0;
        data    = '0;

        unique case (state_q)
            ST_IDLE: begin
                if (pick_any) begin
                    grant_d = pick_idx;
`ifdef PC_TX_ARB_HDR_EN
                    state_d = ST_HDR;
`else
                    state_d = ST_XFER;
                    cnt_d   = '0;
`endif
                end
            end

`ifdef PC_TX_ARB_HDR_EN
            ST_HDR: begin
                data = {HDR_MAGIC, 8'h00, 8'(grant_q)};
                if (!i_fifo_full) begin
                    cmd     = 1'b1;
                    state_d = ST_XFER;
                    cnt_d   = '0;
                end
            end
`endif

            ST_XFER: begin
                data           = word_sel;
                ready[grant_q] = !i_fifo_full;
                cmd            = valid_sel && !i_fifo_full;
                if (!valid_sel) begin
                    state_d = ST_IDLE;
                    last_d  = grant_q;
                end else if (cmd) begin
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_d == BURST_LAST) begin
                        state_d = ST_IDLE;
                        last_d  = grant_q;
                    end
                end
                // A full FIFO with valid data simply holds state, count and grant.
            end

            default: state_d = ST_IDLE;
        endcase

        // Reset is synchronous for state, but the handshake must die in the same cycle.
        if (!i_reset_n) begin
            ready = '0;
            cmd   = 1'b0;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge i_clock) begin
        if (!i_reset_n) begin
            state_q <= ST_IDLE;
            grant_q <= '0;
            last_q  <= IW'(NUM_REQ - 1);
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
        end
    end

    assign o_req_ready            = ready;
    assign o_fifo_write_word_cmd  = cmd;
    assign o_fifo_write_word_data = data;
    assign o_grant_id             = grant_q;
    assign o_busy                 = (state_q != ST_IDLE);

endmodule

// File: tb/tb_pc_tx_arbiter.sv
// Scoreboard bench for pc_tx_arbiter: directed stimulus pushes expected FIFO writes,
// negedge monitors pop and compare. Header words are expected when PC_TX_ARB_HDR_EN is defined.
module tb_pc_tx_arbiter;

    localparam int N = 4;
`ifdef PC_TX_ARB_HDR_EN
    localparam int HDR = 1;
`else
    localparam int HDR = 0;
`endif
    localparam int BW = 8 + HDR;

    typedef struct {
        logic [1:0]  id;
        logic [31:0] data;
    } exp_t;

    logic            clk;
    logic            rst_n;

    logic [N-1:0]    req_valid;
    logic [32*N-1:0] req_data;
    logic [N-1:0]    req_ready;
    logic            fifo_full;
    logic            wr_cmd;
    logic [31:0]     wr_data;
    logic [1:0]      grant_id;
    logic            busy;

    logic [N-1:0]    b_valid;
    logic [32*N-1:0] b_data;
    logic [N-1:0]    b_ready;
    logic            b_full;
    logic            b_cmd;
    logic [31:0]     b_wdata;
    logic [1:0]      b_grant;
    logic            b_busy;

    exp_t exp_q[$];
    exp_t exp1_q[$];
    int   wr_cyc[$];
    int   rem[N];
    int   seq[N];
    int   cyc;
    int   checks;
    int   errors;
    int   c0;

    pc_tx_arbiter #(.NUM_REQ(N), .MAX_BURST(8)) u_dut (
        .i_clock                (clk),
        .i_reset_n              (rst_n),
        .i_req_valid            (req_valid),
        .i_req_data             (req_data),
        .o_req_ready            (req_ready),
        .i_fifo_full            (fifo_full),
        .o_fifo_write_word_cmd  (wr_cmd),
        .o_fifo_write_word_data (wr_data),
        .o_grant_id             (grant_id),
        .o_busy                 (busy)
    );

    pc_tx_arbiter #(.NUM_REQ(N), .MAX_BURST(1)) u_dut_b1 (
        .i_clock                (clk),
        .i_reset_n              (rst_n),
        .i_req_valid            (b_valid),
        .i_req_data             (b_data),
        .o_req_ready            (b_ready),
        .i_fifo_full            (b_full),
        .o_fifo_write_word_cmd  (b_cmd),
        .o_fifo_write_word_data (b_wdata),
        .o_grant_id             (b_grant),
        .o_busy                 (b_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] word(input int k, input int n);
        return 32'hD000_0000 | (32'(k) << 16) | 32'(n & 32'hFFFF);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic push(input int which, input int k, input logic [31:0] d);
        exp_t e;
        e.id   = 2'(k);
        e.data = d;
        if (which == 0) exp_q.push_back(e);
        else            exp1_q.push_back(e);
    endtask

    task automatic push_burst(input int which, input int k, input int first, input int n);
        if (HDR != 0) push(which, k, {16'hA5A5, 8'h00, 8'(k)});
        for (int i = 0; i < n; i++) push(which, k, word(k, first + i));
    endtask

    task automatic apply();
        for (int k = 0; k < N; k++) begin
            req_valid[k]          = (rem[k] > 0);
            req_data[32*k +: 32]  = word(k, seq[k]);
        end
    endtask

    task automatic restart();
        for (int k = 0; k < N; k++) begin
            rem[k] = 0;
            seq[k] = 0;
        end
        wr_cyc.delete();
        apply();
    endtask

    // One clock: sample handshakes before the edge, advance the requester models after it.
    task automatic tick();
        logic [N-1:0] fired;
        @(negedge clk);
        fired = req_valid & req_ready;
        @(posedge clk);
        #1;
        for (int k = 0; k < N; k++) begin
            if (fired[k]) begin
                seq[k]++;
                rem[k]--;
            end
        end
        apply();
    endtask

    task automatic run_until_empty(input int which, input int budget, input string name);
        int n;
        n = 0;
        while (((which == 0) ? exp_q.size() : exp1_q.size()) != 0 && n < budget) begin
            tick();
            n++;
        end
        if (((which == 0) ? exp_q.size() : exp1_q.size()) != 0) begin
            checks++;
            errors++;
            $display("FAIL %s timeout: %0d expected writes never seen", name,
                     (which == 0) ? exp_q.size() : exp1_q.size());
        end
    endtask

    always @(negedge clk) begin
        if (wr_cmd) begin
            exp_t e;
            check("write_while_full", 32'(fifo_full), 32'd0);
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_write: got data %h grant %0d, expected no write", wr_data, grant_id);
            end else begin
                e = exp_q.pop_front();
                check("write_data", wr_data, e.data);
                check("write_grant", 32'(grant_id), 32'(e.id));
            end
            wr_cyc.push_back(cyc);
        end
    end

    always @(negedge clk) begin
        if (b_cmd) begin
            exp_t e;
            if (exp1_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL b1_unexpected_write: got data %h grant %0d, expected no write", b_wdata, b_grant);
            end else begin
                e = exp1_q.pop_front();
                check("b1_write_data", b_wdata, e.data);
                check("b1_write_grant", 32'(b_grant), 32'(e.id));
            end
        end
    end

    initial begin
        checks    = 0;
        errors    = 0;
        cyc       = 0;
        rst_n     = 1'b0;
        fifo_full = 1'b0;
        b_full    = 1'b0;
        b_valid   = '0;
        for (int k = 0; k < N; k++) b_data[32*k +: 32] = word(k, 0);
        restart();

        // Reset state, with a request already pending.
        b_valid = 4'b0001;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_cmd", 32'(wr_cmd), 32'd0);
        check("rst_ready", 32'(req_ready), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_data", wr_data, 32'd0);
        check("rst_grant", 32'(grant_id), 32'd0);
        check("rst_b1_ready", 32'(b_ready), 32'd0);
        b_valid = '0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check("idle_busy", 32'(busy), 32'd0);
        check("idle_data", wr_data, 32'd0);
        check("idle_ready", 32'(req_ready), 32'd0);
        @(posedge clk);
        #1;

        // All four requesters streaming: grants 0,1,2,3,0, bursts of 8, one idle cycle apart.
        restart();
        for (int b = 0; b < 5; b++) push_burst(0, b % 4, (b / 4) * 8, 8);
        for (int k = 0; k < N; k++) rem[k] = 1000;
        apply();
        run_until_empty(0, 200, "stream");
        for (int k = 0; k < N; k++) rem[k] = 0;
        apply();
        check("stream_writes", 32'(wr_cyc.size()), 32'(5 * BW));
        for (int i = 1; i < wr_cyc.size(); i++)
            check("burst_gap", 32'(wr_cyc[i] - wr_cyc[i-1]), (i % BW == 0) ? 32'd2 : 32'd1);
        repeat (3) tick();
        check("stream_idle", 32'(busy), 32'd0);
        check("stream_grant_hold", 32'(grant_id), 32'd0);

        // Requester 2 alone, drops after 3 words; then 1 and 3 valid -> 3 wins.
        restart();
        push_burst(0, 2, 0, 3);
        rem[2] = 3;
        c0 = cyc;
        apply();
        run_until_empty(0, 50, "single");
        check("first_write_latency", 32'(wr_cyc[0] - c0), 32'd1);
        check("first_data_latency", 32'(wr_cyc[HDR] - c0), 32'(1 + HDR));
        repeat (3) tick();
        check("single_idle", 32'(busy), 32'd0);
        check("single_grant_hold", 32'(grant_id), 32'd2);
        push_burst(0, 3, 0, 2);
        push_burst(0, 1, 0, 2);
        rem[1] = 2;
        rem[3] = 2;
        apply();
        run_until_empty(0, 50, "after_2");
        repeat (3) tick();

        // FIFO full for 5 cycles mid-burst.
        restart();
        push_burst(0, 0, 0, 8);
        rem[0] = 8;
        apply();
        for (int n = 0; n < 50 && wr_cyc.size() < 3 + HDR; n++) tick();
        fifo_full = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("full_ready", 32'(req_ready), 32'd0);
            check("full_cmd", 32'(wr_cmd), 32'd0);
            check("full_busy", 32'(busy), 32'd1);
            @(posedge clk);
            #1;
        end
        fifo_full = 1'b0;
        run_until_empty(0, 50, "full");
        check("full_total", 32'(wr_cyc.size()), 32'(BW));
        repeat (3) tick();
        check("full_idle", 32'(busy), 32'd0);

        // Reset pulse while requester 1 would transfer its word 4.
        restart();
        push_burst(0, 1, 0, 4);
        rem[1] = 1000;
        apply();
        run_until_empty(0, 50, "pre_reset");
        rst_n = 1'b0;
        @(negedge clk);
        check("midrst_cmd", 32'(wr_cmd), 32'd0);
        check("midrst_ready", 32'(req_ready), 32'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        rem[0] = 8;
        push_burst(0, 0, 0, 8);
        push_burst(0, 1, 4, 8);
        apply();
        run_until_empty(0, 100, "post_reset");
        for (int k = 0; k < N; k++) rem[k] = 0;
        apply();
        repeat (3) tick();

        // Requester 1 sends two words (preceded by 0xA5A50001 when headers are enabled).
        restart();
        push_burst(0, 1, 0, 2);
        rem[1] = 2;
        apply();
        run_until_empty(0, 50, "two_words");
        repeat (3) tick();

        // MAX_BURST=1 instance: requesters 0 and 3 alternate.
        for (int r = 0; r < 4; r++) push_burst(1, (r % 2 == 0) ? 0 : 3, 0, 1);
        b_valid = 4'b1001;
        run_until_empty(1, 50, "b1_alternate");
        b_valid = '0;
        repeat (3) tick();
        check("b1_idle", 32'(b_busy), 32'd0);
        check("b1_grant_hold", 32'(b_grant), 32'd3);

        check("scoreboard_drained", 32'(exp_q.size() + exp1_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
